// File: rtl/chunk_assigner.sv
// Dispatch stage: pairs chunk descriptors with a free VC and slave, tracks in-flight VCs.
// Optional counters enabled by defining CHUNK_ASSIGNER_STATS_EN.
module chunk_assigner #(
  parameter int unsigned VCHANNELBITS = 3,
  parameter int unsigned SLAVEBITS    = 2,
  parameter int unsigned CHUNKBITS    = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHUNKBITS+63:0]     idx_data,
  input  logic                      idx_empty,
  output logic                      idx_pop,
  input  logic [VCHANNELBITS-1:0]   vc_data,
  input  logic                      vc_empty,
  output logic                      vc_pop,
  input  logic [SLAVEBITS-1:0]      sl_data,
  input  logic                      sl_empty,
  output logic                      sl_pop,
  output logic                      vc_push,
  output logic [VCHANNELBITS-1:0]   vc_push_data,
  output logic                      sl_push,
  output logic [SLAVEBITS-1:0]      sl_push_data,
  output logic                      disp_valid,
  input  logic                      disp_ready,
  output logic [SLAVEBITS-1:0]      disp_slave,
  output logic [VCHANNELBITS-1:0]   disp_vc,
  output logic [CHUNKBITS-1:0]      disp_chunk,
  output logic [31:0]               disp_start,
  output logic [31:0]               disp_end,
  input  logic                      done_valid,
  input  logic [VCHANNELBITS-1:0]   done_vc,
  output logic                      cmpl_valid,
  output logic [CHUNKBITS-1:0]      cmpl_chunk,
  output logic [VCHANNELBITS:0]     inflight,
  output logic                      err_spurious,
  output logic [31:0]               stat_dispatched,
  output logic [31:0]               stat_completed
);

  localparam int unsigned VCHANNELS = 1 << VCHANNELBITS;
  localparam int unsigned CNTBITS   = VCHANNELBITS + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0] state;
  logic [0:0] nextState;
  logic       popQ;
  logic       popD;
  logic       capture;
  logic       handshake;
  logic       headsReady;
  logic       doneHit;
  logic       doneMiss;

  logic                 tblValid [VCHANNELS];
  logic [SLAVEBITS-1:0] tblSlave [VCHANNELS];
  logic [CHUNKBITS-1:0] tblChunk [VCHANNELS];

  assign headsReady = !idx_empty && !vc_empty && !sl_empty;
  assign doneHit    = done_valid && tblValid[done_vc];
  assign doneMiss   = done_valid && !tblValid[done_vc];

  assign idx_pop = popQ;
  assign vc_pop  = popQ;
  assign sl_pop  = popQ;

  // Pops are registered: decided one cycle ahead, heads captured while pop is high.
  always_comb begin
    nextState = state;
    popD      = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (popQ) begin
          capture   = 1'b1;
          nextState = ISSUE;
        end else if (headsReady) begin
          popD = 1'b1;
        end
      end
      ISSUE: begin
        if (disp_ready) begin
          handshake = 1'b1;
          nextState = IDLE;
          popD      = headsReady;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      popQ       <= 1'b0;
      disp_valid <= 1'b0;
      disp_slave <= '0;
      disp_vc    <= '0;
      disp_chunk <= '0;
      disp_start <= '0;
      disp_end   <= '0;
    end else begin
      state      <= nextState;
      popQ       <= popD;
      disp_valid <= (nextState == ISSUE);
      if (capture) begin
        disp_slave <= sl_data;
        disp_vc    <= vc_data;
        disp_chunk <= idx_data[CHUNKBITS+63:64];
        disp_start <= idx_data[63:32];
        disp_end   <= idx_data[31:0];
      end
    end
  end

  // VC ownership table; a done looks at the pre-write state, so same-cycle dispatch reads as spurious.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(VCHANNELS); i++) tblValid[i] <= 1'b0;
    end else begin
      if (doneHit) tblValid[done_vc] <= 1'b0;
      if (handshake) tblValid[disp_vc] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) begin
      tblSlave[disp_vc] <= disp_slave;
      tblChunk[disp_vc] <= disp_chunk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc_push      <= 1'b0;
      vc_push_data <= '0;
      sl_push      <= 1'b0;
      sl_push_data <= '0;
      cmpl_valid   <= 1'b0;
      cmpl_chunk   <= '0;
      inflight     <= '0;
      err_spurious <= 1'b0;
    end else begin
      vc_push    <= doneHit;
      sl_push    <= doneHit;
      cmpl_valid <= doneHit;
      if (doneHit) begin
        vc_push_data <= done_vc;
        sl_push_data <= tblSlave[done_vc];
        cmpl_chunk   <= tblChunk[done_vc];
      end
      if (handshake && !doneHit) inflight <= inflight + CNTBITS'(1);
      else if (!handshake && doneHit) inflight <= inflight - CNTBITS'(1);
      if (doneMiss) err_spurious <= 1'b1;
    end
  end

`ifdef CHUNK_ASSIGNER_STATS_EN
  logic [31:0] statDispQ;
  logic [31:0] statCmplQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statDispQ <= '0;
      statCmplQ <= '0;
    end else begin
      if (handshake) statDispQ <= statDispQ + 32'(1);
      if (doneHit) statCmplQ <= statCmplQ + 32'(1);
    end
  end

  assign stat_dispatched = statDispQ;
  assign stat_completed  = statCmplQ;
`else
  assign stat_dispatched = '0;
  assign stat_completed  = '0;
`endif

endmodule

// File: tb/tb_chunk_assigner.sv
// Directed bench for chunk_assigner with queue-backed free FIFOs driven from one initial block.
module tb_chunk_assigner;

  localparam int unsigned VB = 3;
  localparam int unsigned SB = 2;
  localparam int unsigned CB = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [CB+63:0] idx_data;
  logic          idx_empty;
  logic          idx_pop;
  logic [VB-1:0] vc_data;
  logic          vc_empty;
  logic          vc_pop;
  logic [SB-1:0] sl_data;
  logic          sl_empty;
  logic          sl_pop;
  logic          vc_push;
  logic [VB-1:0] vc_push_data;
  logic          sl_push;
  logic [SB-1:0] sl_push_data;
  logic          disp_valid;
  logic          disp_ready;
  logic [SB-1:0] disp_slave;
  logic [VB-1:0] disp_vc;
  logic [CB-1:0] disp_chunk;
  logic [31:0]   disp_start;
  logic [31:0]   disp_end;
  logic          done_valid;
  logic [VB-1:0] done_vc;
  logic          cmpl_valid;
  logic [CB-1:0] cmpl_chunk;
  logic [VB:0]   inflight;
  logic          err_spurious;
  logic [31:0]   stat_dispatched;
  logic [31:0]   stat_completed;

  int nCmp = 0;
  int nErr = 0;

  logic [CB+63:0] idxQ[$];
  logic [VB-1:0]  vcQ[$];
  logic [SB-1:0]  slQ[$];

  always #5 clk = ~clk;

  chunk_assigner #(.VCHANNELBITS(VB), .SLAVEBITS(SB), .CHUNKBITS(CB)) dut (
    .clk(clk), .rst(rst),
    .idx_data(idx_data), .idx_empty(idx_empty), .idx_pop(idx_pop),
    .vc_data(vc_data), .vc_empty(vc_empty), .vc_pop(vc_pop),
    .sl_data(sl_data), .sl_empty(sl_empty), .sl_pop(sl_pop),
    .vc_push(vc_push), .vc_push_data(vc_push_data),
    .sl_push(sl_push), .sl_push_data(sl_push_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_slave(disp_slave), .disp_vc(disp_vc), .disp_chunk(disp_chunk),
    .disp_start(disp_start), .disp_end(disp_end),
    .done_valid(done_valid), .done_vc(done_vc),
    .cmpl_valid(cmpl_valid), .cmpl_chunk(cmpl_chunk),
    .inflight(inflight), .err_spurious(err_spurious),
    .stat_dispatched(stat_dispatched), .stat_completed(stat_completed)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    idx_empty = (idxQ.size() == 0);
    vc_empty  = (vcQ.size() == 0);
    sl_empty  = (slQ.size() == 0);
    idx_data  = idx_empty ? '0 : idxQ[0];
    vc_data   = vc_empty ? '0 : vcQ[0];
    sl_data   = sl_empty ? '0 : slQ[0];
  endtask

  // Pops visible before the edge are consumed by the FIFO model at that edge.
  task automatic tick();
    logic pI, pV, pS;
    pI = idx_pop; pV = vc_pop; pS = sl_pop;
    @(posedge clk);
    #1;
    if (pI && idxQ.size() > 0) idxQ.delete(0);
    if (pV && vcQ.size() > 0) vcQ.delete(0);
    if (pS && slQ.size() > 0) slQ.delete(0);
    refresh();
  endtask

  task automatic pushAll(input logic [CB-1:0] ch, input logic [31:0] st, input logic [31:0] en,
                         input logic [VB-1:0] vc, input logic [SB-1:0] sl);
    idxQ.push_back({ch, st, en});
    vcQ.push_back(vc);
    slQ.push_back(sl);
    refresh();
  endtask

  task automatic chkIdleOuts(input string tag);
    chk(tag, {idx_pop, vc_pop, sl_pop, vc_push, sl_push, disp_valid, cmpl_valid, err_spurious,
              vc_push_data, sl_push_data, disp_slave, disp_vc, disp_chunk, disp_start, disp_end,
              cmpl_chunk, inflight, stat_dispatched, stat_completed}, '0);
  endtask

  initial begin
    rst = 1'b1;
    disp_ready = 1'b0;
    done_valid = 1'b0;
    done_vc = '0;
    refresh();
    tick();
    tick();
    chkIdleOuts("reset_state");
    rst = 1'b0;

    // single chunk
    disp_ready = 1'b1;
    pushAll(10'd5, 32'd100, 32'd199, 3'd3, 2'd2);
    tick();
    chk("single_pops", {idx_pop, vc_pop, sl_pop, disp_valid}, 4'b1110);
    tick();
    chk("single_disp", {disp_valid, idx_pop, disp_slave, disp_vc, disp_chunk, disp_start, disp_end},
        {1'b1, 1'b0, 2'd2, 3'd3, 10'd5, 32'd100, 32'd199});
    chk("single_inflight_pre", 96'(inflight), 96'd0);
    tick();
    chk("single_hs", {disp_valid, idx_pop, inflight}, {1'b0, 1'b0, 4'd1});

    // completion of vc 3
    done_valid = 1'b1; done_vc = 3'd3;
    tick();
    done_valid = 1'b0;
    chk("cmpl", {vc_push, vc_push_data, sl_push, sl_push_data, cmpl_valid, cmpl_chunk, inflight, err_spurious},
        {1'b1, 3'd3, 1'b1, 2'd2, 1'b1, 10'd5, 4'd0, 1'b0});
    tick();
    chk("cmpl_pulse_end", {vc_push, sl_push, cmpl_valid}, 3'b000);

    // backpressure with a second descriptor already waiting
    disp_ready = 1'b0;
    pushAll(10'd7, 32'h1000, 32'h1fff, 3'd1, 2'd0);
    tick();
    tick();
    pushAll(10'd8, 32'h2000, 32'h2fff, 3'd4, 2'd1);
    for (int i = 0; i < 7; i++) begin
      chk("bp_hold", {disp_valid, idx_pop, vc_pop, sl_pop, disp_chunk, disp_vc, disp_slave, disp_start, disp_end},
          {1'b1, 3'b000, 10'd7, 3'd1, 2'd0, 32'h1000, 32'h1fff});
      tick();
    end
    disp_ready = 1'b1;
    tick();
    chk("bp_hs", {disp_valid, idx_pop, inflight}, {1'b0, 1'b1, 4'd1});
    tick();
    chk("bp_next", {disp_valid, idx_pop, disp_chunk, disp_vc, disp_slave}, {1'b1, 1'b0, 10'd8, 3'd4, 2'd1});
    tick();
    chk("bp_next_hs", {disp_valid, inflight}, {1'b0, 4'd2});

    // starvation on the slave FIFO
    idxQ.push_back({10'd9, 32'd300, 32'd399});
    vcQ.push_back(3'd5);
    refresh();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("starve", {idx_pop, vc_pop, sl_pop, disp_valid}, 4'b0000);
    end
    slQ.push_back(2'd3);
    refresh();
    tick();
    chk("starve_release", {idx_pop, vc_pop, sl_pop}, 3'b111);
    tick();
    chk("starve_disp", {disp_valid, disp_chunk, disp_vc, disp_slave, disp_start}, {1'b1, 10'd9, 3'd5, 2'd3, 32'd300});
    tick();
    chk("starve_hs", 96'(inflight), 96'd3);

    // spurious done on an idle VC
    done_valid = 1'b1; done_vc = 3'd6;
    tick();
    done_valid = 1'b0;
    chk("spur_idle", {err_spurious, vc_push, sl_push, cmpl_valid, inflight}, {1'b1, 3'b000, 4'd3});

    // done coincident with the handshake on the same VC
    disp_ready = 1'b0;
    pushAll(10'd10, 32'd500, 32'd599, 3'd6, 2'd0);
    tick();
    tick();
    chk("coinc_disp", {disp_valid, disp_vc, disp_chunk}, {1'b1, 3'd6, 10'd10});
    disp_ready = 1'b1;
    done_valid = 1'b1; done_vc = 3'd6;
    tick();
    chk("coinc_spur", {vc_push, sl_push, cmpl_valid, inflight, err_spurious}, {3'b000, 4'd4, 1'b1});
    tick();
    done_valid = 1'b0;
    chk("coinc_written", {vc_push, vc_push_data, sl_push, sl_push_data, cmpl_valid, cmpl_chunk, inflight},
        {1'b1, 3'd6, 1'b1, 2'd0, 1'b1, 10'd10, 4'd3});

    // one more dispatch so four chunks are in flight
    pushAll(10'd11, 32'd700, 32'd799, 3'd7, 2'd2);
    tick();
    tick();
    tick();
    chk("four_inflight", {disp_valid, inflight}, {1'b0, 4'd4});
`ifdef CHUNK_ASSIGNER_STATS_EN
    chk("stats_pre_reset", {stat_dispatched, stat_completed}, {32'd6, 32'd2});
`else
    chk("stats_pre_reset", {stat_dispatched, stat_completed}, {32'd0, 32'd0});
`endif

    // reset mid-flight
    rst = 1'b1;
    tick();
    chkIdleOuts("reset_midflight");
    rst = 1'b0;
    done_valid = 1'b1; done_vc = 3'd1;
    tick();
    done_valid = 1'b0;
    chk("post_reset_done", {err_spurious, vc_push, sl_push, cmpl_valid, inflight}, {1'b1, 3'b000, 4'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
